// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: two-stage pixel pipeline into a memory write port, with a full-buffer clear.
// Optional macro FB_CLIP_EN drops pixels that fall outside the framebuffer.
module fb_pixel_writer #(
    parameter int CORDW     = 16,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 180,
    parameter int CIDXW     = 8,
    parameter int BG_CIDX   = 0,
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT,
    localparam int ADDRW     = $clog2(FB_PIXELS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic signed [CORDW-1:0] x,
    input  logic signed [CORDW-1:0] y,
    input  logic        [CIDXW-1:0] cidx,
    input  logic                    drawing,
    input  logic                    frame_done,
    output logic                    fb_we,
    output logic        [ADDRW-1:0] fb_addr,
    output logic        [CIDXW-1:0] fb_din,
    output logic                    ready,
    output logic                    clearing,
    output logic                    frame_ready,
    output logic          [ADDRW:0] pix_cnt,
    output logic                    overflow
);

    typedef enum logic [0:0] {
        ACCEPT = 1'b0,
        CLEAR  = 1'b1
    } state_t;

    localparam logic [ADDRW-1:0] ADDR_LAST_C = ADDRW'(FB_PIXELS - 1);
    localparam logic [ADDRW-1:0] WIDTH_C     = ADDRW'(FB_WIDTH);
    localparam logic   [ADDRW:0] PIX_MAX_C   = (ADDRW + 1)'(FB_PIXELS);
    localparam logic [CIDXW-1:0] BG_C        = CIDXW'(BG_CIDX);

    state_t                  state_r;
    logic        [ADDRW-1:0] clr_addr_r;
    logic                    s1_valid_r;
    logic                    s1_in_fb_r;
    logic                    s1_fd_r;
    logic signed [CORDW-1:0] s1_x_r;
    logic signed [CORDW-1:0] s1_y_r;
    logic        [CIDXW-1:0] s1_cidx_r;
    logic                    in_fb_s;
    logic        [ADDRW-1:0] addr_s;

    assign ready    = (state_r == ACCEPT);
    assign clearing = (state_r == CLEAR);

    // Clip decision on the incoming pixel, registered into stage 1.
    always_comb begin
`ifdef FB_CLIP_EN
        in_fb_s = !x[CORDW-1] && (x < CORDW'(FB_WIDTH)) &&
                  !y[CORDW-1] && (y < CORDW'(FB_HEIGHT));
`else
        in_fb_s = 1'b1;
`endif
    end

    // Linear address in modular ADDRW-bit arithmetic, which matches truncating the signed result.
    always_comb begin
        addr_s = ADDRW'(s1_y_r) * WIDTH_C + ADDRW'(s1_x_r);
    end

    // Mode FSM, pixel pipeline, clear sweep and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ACCEPT;
            clr_addr_r  <= '0;
            s1_valid_r  <= 1'b0;
            s1_in_fb_r  <= 1'b0;
            s1_fd_r     <= 1'b0;
            s1_x_r      <= '0;
            s1_y_r      <= '0;
            s1_cidx_r   <= '0;
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_din      <= '0;
            frame_ready <= 1'b0;
            pix_cnt     <= '0;
            overflow    <= 1'b0;
        end else begin
            if (drawing && (state_r != ACCEPT)) begin
                overflow <= 1'b1;
            end
            case (state_r)
                ACCEPT: begin
                    if (clear) begin
                        // Flush both stages; a pixel or frame_done in flight is discarded.
                        state_r     <= CLEAR;
                        clr_addr_r  <= '0;
                        pix_cnt     <= '0;
                        s1_valid_r  <= 1'b0;
                        s1_fd_r     <= 1'b0;
                        fb_we       <= 1'b0;
                        frame_ready <= 1'b0;
                    end else begin
                        s1_valid_r  <= drawing;
                        s1_in_fb_r  <= in_fb_s;
                        s1_fd_r     <= frame_done;
                        s1_x_r      <= x;
                        s1_y_r      <= y;
                        s1_cidx_r   <= cidx;
                        fb_we       <= s1_valid_r && s1_in_fb_r;
                        frame_ready <= s1_fd_r;
                        if (s1_valid_r && s1_in_fb_r) begin
                            fb_addr <= addr_s;
                            fb_din  <= s1_cidx_r;
                            if (pix_cnt != PIX_MAX_C) begin
                                pix_cnt <= pix_cnt + 1'b1;
                            end
                        end
                    end
                end
                CLEAR: begin
                    fb_we       <= 1'b1;
                    fb_addr     <= clr_addr_r;
                    fb_din      <= BG_C;
                    s1_valid_r  <= 1'b0;
                    s1_fd_r     <= 1'b0;
                    frame_ready <= 1'b0;
                    if (clr_addr_r == ADDR_LAST_C) begin
                        state_r <= ACCEPT;
                    end else begin
                        clr_addr_r <= clr_addr_r + 1'b1;
                    end
                end
                default: begin
                    state_r     <= ACCEPT;
                    fb_we       <= 1'b0;
                    s1_valid_r  <= 1'b0;
                    s1_fd_r     <= 1'b0;
                    frame_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer: expected writes are queued at stimulus time and popped by a monitor.
module tb_fb_pixel_writer;
    localparam int FB_PIXELS = 57600;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clear = 1'b0;
    logic signed [15:0] x = '0;
    logic signed [15:0] y = '0;
    logic        [7:0]  cidx = '0;
    logic               drawing = 1'b0;
    logic               frame_done = 1'b0;
    logic               fb_we;
    logic        [15:0] fb_addr;
    logic        [7:0]  fb_din;
    logic               ready;
    logic               clearing;
    logic               frame_ready;
    logic        [16:0] pix_cnt;
    logic               overflow;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  din;
        logic        fr;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  tests = 0;
    int  fails = 0;
    int  exp_cnt = 0;
    int  clr_cycles;

    fb_pixel_writer dut (
        .clk(clk), .rst(rst), .clear(clear), .x(x), .y(y), .cidx(cidx),
        .drawing(drawing), .frame_done(frame_done), .fb_we(fb_we), .fb_addr(fb_addr),
        .fb_din(fb_din), .ready(ready), .clearing(clearing), .frame_ready(frame_ready),
        .pix_cnt(pix_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input int d, input logic fr);
        wr_t e;
        e.addr = a[15:0];
        e.din  = d[7:0];
        e.fr   = fr;
        exp_q.push_back(e);
    endtask

    // Present one pixel for one cycle; queue its write if one is expected.
    task automatic draw(input int px, input int py, input int c, input logic fd,
                        input logic wr, input int ea);
        x = px[15:0];
        y = py[15:0];
        cidx = c[7:0];
        drawing = 1'b1;
        frame_done = fd;
        if (wr) begin
            push(ea, c, fd);
            exp_cnt++;
        end
        step();
        drawing = 1'b0;
        frame_done = 1'b0;
    endtask

    // Start a clear (optionally with a pixel and frame_done in the same cycle); abort with rst at abort_at.
    task automatic run_clear(input int abort_at, input logic with_pix, output int cycles);
        int k = 0;
        int guard = 0;
        clear = 1'b1;
        drawing = with_pix;
        frame_done = with_pix;
        step();
        clear = 1'b0;
        drawing = 1'b0;
        frame_done = 1'b0;
        exp_cnt = 0;
        chk("clear_start_clearing", clearing, 1);
        chk("clear_start_ready", ready, 0);
        chk("clear_start_pix_cnt", pix_cnt, 0);
        chk("clear_start_fb_we", fb_we, 0);
        cycles = 1;
        while (clearing && guard < 70000) begin
            if (cycles == abort_at) rst = 1'b1;
            else push(k++, 0, 1'b0);
            if (cycles == 50) clear = 1'b1;
            if (cycles == 100) begin
                drawing = 1'b1;
                x = 16'sd1;
                y = 16'sd1;
                cidx = 8'hAA;
            end
            step();
            rst = 1'b0;
            clear = 1'b0;
            drawing = 1'b0;
            guard++;
            if (clearing) cycles++;
        end
        chk("clear_bounded", guard < 70000, 1);
    endtask

    // Monitor: every write the DUT issues must match the head of the expected queue.
    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d din %0h, expected no write", fb_addr, fb_din);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", fb_addr, mon_e.addr);
                chk("wr_din", fb_din, mon_e.din);
                chk("wr_frame_ready", frame_ready, mon_e.fr);
            end
        end else if (frame_ready === 1'b1) begin
            tests++;
            fails++;
            $display("FAIL stray_frame_ready: got 1 without a write, expected 0");
        end
    end

    initial begin
        repeat (3) step();
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_din", fb_din, 0);
        chk("rst_pix_cnt", pix_cnt, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_ready", frame_ready, 0);
        chk("rst_ready", ready, 1);
        chk("rst_clearing", clearing, 0);
        rst = 1'b0;
        step();

        // Basic two-cycle latency
        draw(5, 2, 8'h3C, 1'b0, 1'b1, 645);
        chk("lat_n1_fb_we", fb_we, 0);
        step();
        chk("lat_n2_fb_we", fb_we, 1);
        chk("lat_n2_fb_addr", fb_addr, 645);
        chk("lat_n2_fb_din", fb_din, 8'h3C);
        chk("lat_n2_pix_cnt", pix_cnt, 1);

        // Back-to-back pixels
        draw(0, 0, 8'h11, 1'b0, 1'b1, 0);
        draw(319, 0, 8'h22, 1'b0, 1'b1, 319);
        draw(10, 100, 8'h33, 1'b0, 1'b1, 32010);
        step();
        step();
        chk("b2b_pix_cnt", pix_cnt, 4);
        chk("b2b_overflow", overflow, 0);

        // Pixel+frame_done in flight, then clear together with a pixel; rst at clear cycle 10
        x = 16'sd3;
        y = 16'sd3;
        cidx = 8'h77;
        drawing = 1'b1;
        frame_done = 1'b1;
        step();
        run_clear(10, 1'b1, clr_cycles);
        chk("abort_cycles", clr_cycles, 10);
        chk("abort_fb_we", fb_we, 0);
        chk("abort_ready", ready, 1);
        chk("abort_clearing", clearing, 0);
        chk("abort_pix_cnt", pix_cnt, 0);
        chk("abort_overflow", overflow, 0);
        chk("abort_frame_ready", frame_ready, 0);
        step();
        step();
        chk("abort_idle_fb_we", fb_we, 0);

        // Full clear, with an ignored clear at cycle 50 and a dropped pixel at cycle 100
        run_clear(-1, 1'b0, clr_cycles);
        chk("clear_cycles", clr_cycles, FB_PIXELS);
        chk("clear_done_ready", ready, 1);
        chk("clear_done_last_addr", fb_addr, FB_PIXELS - 1);
        chk("clear_done_last_din", fb_din, 0);
        chk("clear_done_overflow", overflow, 1);
        chk("clear_done_pix_cnt", pix_cnt, 0);
        step();
        chk("clear_after_fb_we", fb_we, 0);

        // Overflow remains sticky through normal drawing
        draw(7, 3, 8'h44, 1'b0, 1'b1, 967);
        step();
        step();
        chk("post_pix_cnt", pix_cnt, 1);
        chk("post_overflow", overflow, 1);

        // Edge coordinates: clipped with FB_CLIP_EN, address-truncated without
`ifdef FB_CLIP_EN
        draw(-1, 0, 8'h51, 1'b0, 1'b0, 0);
        draw(320, 0, 8'h52, 1'b0, 1'b0, 0);
        draw(0, 180, 8'h53, 1'b0, 1'b0, 0);
        step();
        step();
        chk("clip_pix_cnt", pix_cnt, 1);
`else
        draw(-1, 0, 8'h51, 1'b0, 1'b1, 65535);
        draw(320, 0, 8'h52, 1'b0, 1'b1, 320);
        draw(0, 180, 8'h53, 1'b0, 1'b1, 57600);
        step();
        step();
        chk("noclip_pix_cnt", pix_cnt, 4);
`endif
        draw(319, 179, 8'h55, 1'b0, 1'b1, 57599);
        step();
        chk("corner_fb_addr", fb_addr, 57599);
        chk("corner_pix_cnt", pix_cnt, exp_cnt);
        step();

        // Last two raster rows every 3 cycles, frame_done with the final pixel
        for (int yy = 178; yy < 180; yy++) begin
            for (int xx = 0; xx < 320; xx++) begin
                if (!(yy == 179 && xx == 319)) begin
                    draw(xx, yy, (yy * 320 + xx) & 255, 1'b0, 1'b1, yy * 320 + xx);
                    step();
                    step();
                end
            end
        end
        draw(319, 179, 57599 & 255, 1'b1, 1'b1, 57599);
        step();
        chk("frame_ready_pulse", frame_ready, 1);
        chk("frame_last_addr", fb_addr, 57599);
        chk("frame_pix_cnt", pix_cnt, exp_cnt);
        step();
        chk("frame_ready_one_cycle", frame_ready, 0);

        // Only rst clears overflow
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("final_overflow", overflow, 0);
        chk("final_pix_cnt", pix_cnt, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
